// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg: shared defaults and lock-state type for the pipelined round-robin arbiter.
// Contents: DEFAULT_WIDTH, DEFAULT_N_REQ, DEFAULT_LATENCY, lock_state_t (IDLE, LOCKED).
package pipe_arb_pkg;
    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_LATENCY = 1;
    typedef enum logic {IDLE, LOCKED} lock_state_t;
endpackage

// File: rtl/pipe_rr_arbiter_if.sv
// pipe_rr_arbiter_if: requester, shared-datapath and response signals of the arbiter.
// Signals: req_valid/req_data/req_ready (requesters), dp_data/dp_result (shared datapath),
//          rsp_valid/rsp_id/rsp_data (responses), req_lock when PIPE_ARB_LOCK_EN is defined.
// Modports: master = requesters + datapath side, slave = the arbiter.
interface pipe_rr_arbiter_if
    import pipe_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_REQ = DEFAULT_N_REQ
);
    localparam int IDW = $clog2(N_REQ);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       dp_data;
    logic [WIDTH-1:0]       dp_result;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_data;
`ifdef PIPE_ARB_LOCK_EN
    logic [N_REQ-1:0]       req_lock;
`endif
    modport master (
        output req_valid, req_data, dp_result,
        input  req_ready, dp_data, rsp_valid, rsp_id, rsp_data
`ifdef PIPE_ARB_LOCK_EN
        , output req_lock
`endif
    );
    modport slave (
        input  req_valid, req_data, dp_result,
        output req_ready, dp_data, rsp_valid, rsp_id, rsp_data
`ifdef PIPE_ARB_LOCK_EN
        , input req_lock
`endif
    );
endinterface

// File: rtl/pipe_tag_delay.sv
// pipe_tag_delay: DEPTH-stage shift register for TW-bit tags, one entry per cycle.
// Ports: clk, rst (sync active-low, clears all stages), in (tag entering), out (tag DEPTH cycles later).
module pipe_tag_delay #(
    parameter int DEPTH = 1,
    parameter int TW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] in,
    output logic [TW-1:0] out
);
    logic [TW-1:0] stage [DEPTH];
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign out = stage[DEPTH-1];
endmodule

// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter: round-robin arbiter feeding a fixed-latency shared datapath, returning tagged results.
// Ports: clk; rst (sync active-low); bus (pipe_rr_arbiter_if.slave): req_valid/req_data/req_ready,
//        dp_data/dp_result, rsp_valid/rsp_id/rsp_data.
// Macro PIPE_ARB_LOCK_EN: adds req_lock and an IDLE/LOCKED owner lock; default build is pure round-robin.
module pipe_rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input logic              clk,
    input logic              rst,
    pipe_rr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    logic [IDW-1:0] ptr, gid, idx;
    logic           found, xfer;
    logic [IDW:0]   tag_out;
`ifdef PIPE_ARB_LOCK_EN
    lock_state_t    state;
    logic [IDW-1:0] owner;
`endif
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] k);
        return (k == IDW'(N_REQ - 1)) ? '0 : k + 1'b1;
    endfunction
    // Scan from ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        idx   = '0;
`ifdef PIPE_ARB_LOCK_EN
        if (state == LOCKED) begin
            found = bus.req_valid[owner];
            gid   = owner;
        end else begin
`else
        begin
`endif
            for (int i = 0; i < N_REQ; i++) begin
                idx = IDW'((int'(ptr) + i) % N_REQ);
                if (!found && bus.req_valid[idx]) begin
                    found = 1'b1;
                    gid   = idx;
                end
            end
        end
    end
    assign xfer          = found && rst;
    assign bus.req_ready = xfer ? N_REQ'(1) << gid : '0;
    assign bus.dp_data   = xfer ? bus.req_data[gid*WIDTH +: WIDTH] : '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr   <= '0;
`ifdef PIPE_ARB_LOCK_EN
            state <= IDLE;
            owner <= '0;
`endif
        end else begin
`ifdef PIPE_ARB_LOCK_EN
            // ptr stays frozen while locked; release resumes just past the owner.
            if (state == LOCKED) begin
                if (!bus.req_valid[owner] || !bus.req_lock[owner]) begin
                    state <= IDLE;
                    ptr   <= wrap_inc(owner);
                end
            end else if (xfer) begin
                if (bus.req_lock[gid]) begin
                    state <= LOCKED;
                    owner <= gid;
                end else begin
                    ptr <= wrap_inc(gid);
                end
            end
`else
            if (xfer) ptr <= wrap_inc(gid);
`endif
        end
    end
    // Tags enter every cycle, bubbles included, so the result lines up with dp_result.
    pipe_tag_delay #(.DEPTH(LATENCY), .TW(IDW + 1)) u_tag (
        .clk (clk),
        .rst (rst),
        .in  ({xfer, gid}),
        .out (tag_out)
    );
    assign bus.rsp_valid = tag_out[IDW] && rst;
    assign bus.rsp_id    = bus.rsp_valid ? tag_out[IDW-1:0] : '0;
    assign bus.rsp_data  = bus.rsp_valid ? bus.dp_result : '0;
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// tb_pipe_rr_arbiter: table-driven check of pipe_rr_arbiter (WIDTH=8, N_REQ=4, LATENCY=1).
// The bench models the shared datapath as a one-cycle identity register.
module tb_pipe_rr_arbiter;
    import pipe_arb_pkg::*;
    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  ready;
        logic [7:0]  dp;
        logic        rv;
        logic [1:0]  id;
        logic [7:0]  rd;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    pipe_rr_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus ();
    pipe_rr_arbiter #(.WIDTH(8), .N_REQ(4), .LATENCY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) bus.dp_result <= bus.dp_data;
    function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] rdy,
                                logic [7:0] dp, logic rv, logic [1:0] id, logic [7:0] rd);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.ready = rdy;
        x.dp = dp; x.rv = rv; x.id = id; x.rd = rd;
        return x;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic check_all(input string tag, input logic [3:0] rdy, input logic [7:0] dp,
                             input logic rv, input logic [1:0] id, input logic [7:0] rd);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(rdy));
        chk({tag, ".dp_data"},   32'(bus.dp_data),   32'(dp));
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
        chk({tag, ".rsp_id"},    32'(bus.rsp_id),    32'(id));
        chk({tag, ".rsp_data"},  32'(bus.rsp_data),  32'(rd));
    endtask
    localparam logic [31:0] ALL = 32'h3322_1100;
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
`ifdef PIPE_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        // reset held with everyone requesting
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b1111, ALL, 4'b0000, 8'h00, 0, 0, 8'h00));
        // full contention from ptr=0
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b0001, 8'h00, 0, 0, 8'h00));
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b0010, 8'h11, 1, 0, 8'h00));
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b0100, 8'h22, 1, 1, 8'h11));
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b1000, 8'h33, 1, 2, 8'h22));
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b0001, 8'h00, 1, 3, 8'h33));
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b0010, 8'h11, 1, 0, 8'h00));
        // sparse wrap from ptr=2 with reqs 1 and 3, then ptr back at 2
        tbl.push_back(mk(1, 4'b1010, ALL, 4'b1000, 8'h33, 1, 1, 8'h11));
        tbl.push_back(mk(1, 4'b1010, ALL, 4'b0010, 8'h11, 1, 3, 8'h33));
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b0100, 8'h22, 1, 1, 8'h11));
        // idle cycle keeps ptr=3; next search wraps past 3 to 0
        tbl.push_back(mk(1, 4'b0000, ALL, 4'b0000, 8'h00, 1, 2, 8'h22));
        tbl.push_back(mk(1, 4'b0011, ALL, 4'b0001, 8'h00, 0, 0, 8'h00));
        // single requester 2 streaming 0x00..0x09
        for (int j = 0; j < 10; j++)
            tbl.push_back(mk(1, 4'b0100, {8'h33, 8'(j), 8'h11, 8'h00}, 4'b0100, 8'(j), 1,
                             (j == 0) ? 2'd0 : 2'd2, (j == 0) ? 8'h00 : 8'(j - 1)));
        tbl.push_back(mk(1, 4'b0000, ALL, 4'b0000, 8'h00, 1, 2, 8'h09));
        // reset right after granting 0x5A: its response must never appear, ptr returns to 0
        tbl.push_back(mk(1, 4'b0010, 32'h0000_5A00, 4'b0010, 8'h5A, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0010, 32'h0000_5A00, 4'b0000, 8'h00, 0, 0, 8'h00));
        tbl.push_back(mk(1, 4'b0000, ALL, 4'b0000, 8'h00, 0, 0, 8'h00));
        tbl.push_back(mk(1, 4'b1111, ALL, 4'b0001, 8'h00, 0, 0, 8'h00));
        tbl.push_back(mk(1, 4'b0000, ALL, 4'b0000, 8'h00, 1, 0, 8'h00));
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst           = tbl[i].rst;
            bus.req_valid = tbl[i].valid;
            bus.req_data  = tbl[i].data;
            #1;
            check_all($sformatf("v%0d", i), tbl[i].ready, tbl[i].dp, tbl[i].rv, tbl[i].id, tbl[i].rd);
        end
`ifdef PIPE_ARB_LOCK_EN
        // reset to ptr=0, then req 0 locks for three grants while req 1 waits
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 4'b0011;
        bus.req_lock  = 4'b0001;
        bus.req_data  = ALL;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_all($sformatf("lock%0d", k), 4'b0001, 8'h00, k != 0, 2'd0, 8'h00);
            @(negedge clk);
        end
        bus.req_valid = 4'b0010;
        bus.req_lock  = 4'b0000;
        #1;
        check_all("lock_release", 4'b0000, 8'h00, 1, 2'd0, 8'h00);
        @(negedge clk);
        #1;
        check_all("lock_next", 4'b0010, 8'h11, 0, 2'd0, 8'h00);
`endif
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_rr_arbiter.md
PIPE_RR_ARBITER -- requirements
Module: pipe_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each requester and of the shared datapath.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters, range 2..16.
REQ-003 SHALL have parameter LATENCY, default 1, fixed cycles from dp_data to dp_result, minimum 1.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester request.
REQ-007 SHALL have port req_data  input  N_REQ*WIDTH  requester k in bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot grant; transfer when valid&ready.
REQ-009 SHALL have port dp_data  output  WIDTH  to shared datapath i_data.
REQ-010 SHALL have port dp_result  input  WIDTH  from shared datapath o_data.
REQ-011 SHALL have port rsp_valid  output  1  result available this cycle.
REQ-012 SHALL have port rsp_id  output  IDW  originating requester; IDW = $clog2(N_REQ).
REQ-013 SHALL have port rsp_data  output  WIDTH  result data.

Function
REQ-014 SHALL grant, combinationally, the first valid requester at or after round-robin pointer ptr, wrapping N_REQ-1 -> 0.
REQ-015 SHALL assert at most one req_ready bit; all zero when no req_valid or rst low.
REQ-016 SHALL drive dp_data = granted req_data, else all-zero.
REQ-017 SHALL set ptr to (grant+1) mod N_REQ after each transfer; ptr unchanged on idle cycles.
REQ-018 SHALL carry {valid, id} through an LATENCY-deep tag delay line, one entry per cycle, bubbles included.
REQ-019 SHALL assert rsp_valid exactly LATENCY cycles after a transfer, with rsp_id = granted index.
REQ-020 SHALL drive rsp_data = dp_result when rsp_valid, else zero; rsp_id zero when not rsp_valid.
REQ-021 SHALL sustain one transfer per cycle; no requester starved longer than N_REQ-1 grants.

Reset
REQ-022 SHALL, on rst low at a rising edge, clear ptr to 0, all tag stages, and lock state.
REQ-023 SHALL drop in-flight transactions on reset mid-operation: rsp_valid 0 from the first cycle after the reset edge until new transfers mature.
REQ-024 SHALL hold req_ready=0, dp_data=0, rsp_valid=0, rsp_id=0, rsp_data=0 while rst low.

Configuration
REQ-025 SHALL, with macro PIPE_ARB_LOCK_EN defined, add input req_lock (N_REQ); states IDLE/LOCKED: transfer with req_lock[g]=1 -> LOCKED owner=g; in LOCKED only owner granted, ptr frozen; owner transfer with lock=0 or owner valid=0 -> IDLE, ptr=owner+1.
REQ-026 SHALL, without PIPE_ARB_LOCK_EN, omit req_lock and lock state; pure round-robin per REQ-014..017.

Structure
REQ-027 SHALL place DEFAULT_WIDTH, DEFAULT_N_REQ, DEFAULT_LATENCY and lock state enum (IDLE, LOCKED) in package pipe_arb_pkg.
REQ-028 SHALL implement the tag delay line as sub-module pipe_tag_delay (params DEPTH, TW; clk, rst, in, out).

Verification (WIDTH=8, N_REQ=4, LATENCY=1)
REQ-029 Reset: rst=0 3 cycles, all req_valid=1 -> req_ready=0000, dp_data=0x00, rsp_valid=0; first edge after release grants req 0.
REQ-030 Single: req 2 valid 10 cycles, data 0x00..0x09 -> req_ready=0100 each cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=same value.
REQ-031 Full contention: all valid, data k*0x11 -> grants 0,1,2,3,0,1; rsp_id same one cycle later, rsp_data 0x00,0x11,0x22,0x33.
REQ-032 Sparse wrap: ptr=2, reqs 1 and 3 valid -> grant 3 then 1, then ptr=2.
REQ-033 Reset mid-stream: grant req 1 data 0x5A, rst=0 next edge -> no rsp_valid for 0x5A.
REQ-034 Lock (PIPE_ARB_LOCK_EN): req 0 valid+lock 3 cycles, req 1 valid -> grants 0,0,0, drop lock -> grant 1.
